// File: rtl/datamemory_be.sv
// Byte-addressed RAM with RISC-V load/store widths; responses after RD_LAT cycles, in order.
// Accepts one request per cycle in RUN. Responses are never stalled. No requests are taken while clearing.
module datamemory_be #(
    parameter int DM_ADDRESS     = 9,
    parameter int DATA_W         = 32,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     rd,
    output logic                  busy
);
    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = DM_ADDRESS - OFF_W;
    localparam int WORDS = 1 << IDX_W;

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic             we;
        logic             err;
        logic [1:0]       size;
        logic             uns;
        logic [OFF_W-1:0] off;
    } ctl_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_idx;
    logic [DATA_W-1:0] mem [WORDS];

    logic [IDX_W-1:0]  widx;
    logic [OFF_W-1:0]  off;
    logic [1:0]        size;
    logic              legal;
    logic              misaligned;
    logic              err;
    logic              accept;
    logic              do_store;
    logic [B-1:0]      be;
    logic [DATA_W-1:0] wdata;
    ctl_t              ctl;

    logic [RD_LAT-1:0] pv;
    ctl_t              pctl [RD_LAT];
    logic [DATA_W-1:0] pdat [RD_LAT];
    ctl_t              last_ctl;
    logic [DATA_W-1:0] lv_shift;
    int                lv_pad;
    logic [DATA_W-1:0] load_val;

    assign widx     = a[DM_ADDRESS-1:OFF_W];
    assign off      = a[OFF_W-1:0];
    assign size     = Funct3[1:0];
    assign accept   = req_valid && req_ready && !reset;
    assign err      = !legal || misaligned;
    assign do_store = accept && req_we && !err;
    assign wdata    = wd << {off, 3'b000};
    assign ctl      = '{we: req_we, err: err, size: size, uns: Funct3[2], off: off};

    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            case (Funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (DATA_W == 64);
                default:                legal = 1'b0;
            endcase
        end else begin
            case (Funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (DATA_W == 64);
                default:                                legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a[1:0];
            2'd3:    misaligned = |a[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be = '0;
        for (int i = 0; i < B; i++)
            be[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state     <= CLEAR;
                busy      <= 1'b1;
                req_ready <= 1'b0;
            end else begin
                state     <= RUN;
                busy      <= 1'b0;
                req_ready <= 1'b1;
            end
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(WORDS - 1)) begin
                        state     <= RUN;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Store bytes land on the accept edge, so a load accepted one edge later sees them.
    always_ff @(posedge clk) begin
        if (state == CLEAR && !reset) begin
            mem[clr_idx] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < B; i++)
                if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        if (accept) begin
            pdat[0] <= mem[widx];
            pctl[0] <= ctl;
        end
        for (int k = 1; k < RD_LAT; k++) begin
            pdat[k] <= pdat[k-1];
            pctl[k] <= pctl[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv <= '0;
        end else begin
            pv[0] <= accept;
            for (int k = 1; k < RD_LAT; k++) pv[k] <= pv[k-1];
        end
    end

    assign last_ctl = pctl[RD_LAT-1];

    // Extension by shifting the field to the top and back down, arithmetic for signed codes.
    always_comb begin
        lv_shift = pdat[RD_LAT-1] >> {last_ctl.off, 3'b000};
        lv_pad   = ((8 << last_ctl.size) >= DATA_W) ? 0 : DATA_W - (8 << last_ctl.size);
        if (last_ctl.uns) load_val = (lv_shift << lv_pad) >> lv_pad;
        else              load_val = $signed(lv_shift << lv_pad) >>> lv_pad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd        <= '0;
        end else begin
            rsp_valid <= pv[RD_LAT-1];
            if (pv[RD_LAT-1]) begin
                rsp_err <= last_ctl.err;
                rd      <= (last_ctl.err || last_ctl.we) ? '0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_datamemory_be.sv
// Three builds share one stimulus stream: 32-bit/RD_LAT=1, 32-bit/RD_LAT=3, 64-bit/RD_LAT=1.
module tb_datamemory_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [8:0]  a;
    logic [63:0] wd;

    logic        rdy_a, rv_a, re_a, busy_a;
    logic [31:0] rd_a;
    logic        rdy_b, rv_b, re_b, busy_b;
    logic [31:0] rd_b;
    logic        rdy_c, rv_c, re_c, busy_c;
    logic [63:0] rd_c;

    datamemory_be #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
        .Funct3(funct3), .a(a), .wd(wd[31:0]), .rsp_valid(rv_a), .rsp_err(re_a), .rd(rd_a), .busy(busy_a));

    datamemory_be #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
        .Funct3(funct3), .a(a), .wd(wd[31:0]), .rsp_valid(rv_b), .rsp_err(re_b), .rd(rd_b), .busy(busy_b));

    datamemory_be #(.DM_ADDRESS(9), .DATA_W(64), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_c), .req_we(req_we),
        .Funct3(funct3), .a(a), .wd(wd), .rsp_valid(rv_c), .rsp_err(re_c), .rd(rd_c), .busy(busy_c));

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [63:0] rd;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [63:0] wd;
        logic        e32;
        logic [31:0] r32;
        logic        e64;
        logic [63:0] r64;
    } vec_t;

    rsp_t qa[$];
    rsp_t qb[$];
    rsp_t qc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt[25];
    int   acc;
    int   accs[6];
    logic [31:0] seq_exp[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rv_a) qa.push_back(rsp_t'({cyc[31:0], re_a, 32'd0, rd_a}));
        if (rv_b) qb.push_back(rsp_t'({cyc[31:0], re_b, 32'd0, rd_b}));
        if (rv_c) qc.push_back(rsp_t'({cyc[31:0], re_c, rd_c}));
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, {61'd0, rv_a, rv_b, rv_c}, 64'h0);
        check({tag, "_rsp_err"},   {61'd0, re_a, re_b, re_c}, 64'h0);
        check({tag, "_rd32"},      {rd_a, rd_b}, 64'h0);
        check({tag, "_rd64"},      rd_c, 64'h0);
        check({tag, "_busy"},      {61'd0, busy_a, busy_b, busy_c}, 64'h7);
        check({tag, "_req_ready"}, {61'd0, rdy_a, rdy_b, rdy_c}, 64'h0);
    endtask

    // Releases reset and counts cycles with busy high on each build.
    task automatic clear_pass(input string tag);
        int na, nb, nc;
        bit done, mism;
        na = 0; nb = 0; nc = 0; done = 0; mism = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            #1;
            if (busy_a) na++;
            if (busy_b) nb++;
            if (busy_c) nc++;
            if (rdy_a == busy_a || rdy_b == busy_b || rdy_c == busy_c) mism = 1;
            if (!busy_a && !busy_b && !busy_c) done = 1;
            else @(negedge clk);
        end
        check({tag, "_clear_done"}, {63'd0, done}, 64'h1);
        check({tag, "_ready_vs_busy"}, {63'd0, mism}, 64'h0);
        check({tag, "_busy_cycles_a"}, 64'(na), 64'd128);
        check({tag, "_busy_cycles_b"}, 64'(nb), 64'd128);
        check({tag, "_busy_cycles_c"}, 64'(nc), 64'd64);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] ad,
                         input logic [63:0] d, output int acc_cyc);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; funct3 = f3; a = ad; wd = d;
        check("req_ready", {61'd0, rdy_a, rdy_b, rdy_c}, 64'h7);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic expect_rsp(input int id, input int acc_cyc, input logic e_err, input logic [63:0] e_rd);
        rsp_t r;
        bit   ok;
        int   lat;
        ok  = 0;
        r   = '0;
        lat = (id == 1) ? 3 : 1;
        case (id)
            0: if (qa.size() > 0) begin r = qa.pop_front(); ok = 1; end
            1: if (qb.size() > 0) begin r = qb.pop_front(); ok = 1; end
            default: if (qc.size() > 0) begin r = qc.pop_front(); ok = 1; end
        endcase
        check($sformatf("rsp_present_i%0d", id), {63'd0, ok}, 64'h1);
        if (ok) begin
            check($sformatf("rsp_latency_i%0d", id), 64'(r.cyc - 32'(acc_cyc)), 64'(lat));
            check($sformatf("rsp_err_i%0d", id), {63'd0, r.err}, {63'd0, e_err});
            check($sformatf("rsp_rd_i%0d", id), r.rd, e_rd);
        end
    endtask

    initial begin
        vt[0]  = '{1'b0, 3'b010, 9'h1FC, 64'h0,                   1'b0, 32'h0,        1'b0, 64'h0};
        vt[1]  = '{1'b1, 3'b011, 9'h000, 64'hDEADBEEF_01234567,   1'b1, 32'h0,        1'b0, 64'h0};
        vt[2]  = '{1'b0, 3'b110, 9'h004, 64'h0,                   1'b1, 32'h0,        1'b0, 64'h00000000_DEADBEEF};
        vt[3]  = '{1'b0, 3'b010, 9'h004, 64'h0,                   1'b0, 32'h0,        1'b0, 64'hFFFFFFFF_DEADBEEF};
        vt[4]  = '{1'b0, 3'b011, 9'h000, 64'h0,                   1'b1, 32'h0,        1'b0, 64'hDEADBEEF_01234567};
        vt[5]  = '{1'b1, 3'b010, 9'h010, 64'h8899AABB,            1'b0, 32'h0,        1'b0, 64'h0};
        vt[6]  = '{1'b0, 3'b000, 9'h012, 64'h0,                   1'b0, 32'hFFFFFF99, 1'b0, 64'hFFFFFFFF_FFFFFF99};
        vt[7]  = '{1'b0, 3'b100, 9'h012, 64'h0,                   1'b0, 32'h00000099, 1'b0, 64'h00000000_00000099};
        vt[8]  = '{1'b0, 3'b001, 9'h012, 64'h0,                   1'b0, 32'hFFFF8899, 1'b0, 64'hFFFFFFFF_FFFF8899};
        vt[9]  = '{1'b0, 3'b101, 9'h012, 64'h0,                   1'b0, 32'h00008899, 1'b0, 64'h00000000_00008899};
        vt[10] = '{1'b1, 3'b010, 9'h020, 64'hFFFFFFFF_11223344,   1'b0, 32'h0,        1'b0, 64'h0};
        vt[11] = '{1'b1, 3'b000, 9'h021, 64'hFFFFFFFF_FFFF12EE,   1'b0, 32'h0,        1'b0, 64'h0};
        vt[12] = '{1'b1, 3'b001, 9'h022, 64'hFFFFFFFF_ABCDCAFE,   1'b0, 32'h0,        1'b0, 64'h0};
        vt[13] = '{1'b0, 3'b010, 9'h020, 64'h0,                   1'b0, 32'hCAFEEE44, 1'b0, 64'hFFFFFFFF_CAFEEE44};
        vt[14] = '{1'b1, 3'b010, 9'h030, 64'h55667788,            1'b0, 32'h0,        1'b0, 64'h0};
        vt[15] = '{1'b1, 3'b001, 9'h031, 64'h1234,                1'b1, 32'h0,        1'b1, 64'h0};
        vt[16] = '{1'b0, 3'b010, 9'h032, 64'h0,                   1'b1, 32'h0,        1'b1, 64'h0};
        vt[17] = '{1'b0, 3'b010, 9'h030, 64'h0,                   1'b0, 32'h55667788, 1'b0, 64'h00000000_55667788};
        vt[18] = '{1'b0, 3'b111, 9'h030, 64'h0,                   1'b1, 32'h0,        1'b1, 64'h0};
        vt[19] = '{1'b1, 3'b100, 9'h030, 64'hFF,                  1'b1, 32'h0,        1'b1, 64'h0};
        vt[20] = '{1'b0, 3'b010, 9'h030, 64'h0,                   1'b0, 32'h55667788, 1'b0, 64'h00000000_55667788};
        vt[21] = '{1'b0, 3'b011, 9'h030, 64'h0,                   1'b1, 32'h0,        1'b0, 64'h00000000_55667788};
        vt[22] = '{1'b1, 3'b011, 9'h034, 64'h1111111122222222,    1'b1, 32'h0,        1'b1, 64'h0};
        vt[23] = '{1'b0, 3'b000, 9'h013, 64'h0,                   1'b0, 32'hFFFFFF88, 1'b0, 64'hFFFFFFFF_FFFFFF88};
        vt[24] = '{1'b0, 3'b011, 9'h020, 64'h0,                   1'b1, 32'h0,        1'b0, 64'h00000000_CAFEEE44};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000; a = '0; wd = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        clear_pass("por");

        for (int i = 0; i < 25; i++) begin
            issue(vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, acc);
            @(negedge clk);
            req_valid = 1'b0;
            repeat (4) @(negedge clk);
            expect_rsp(0, acc, vt[i].e32, {32'd0, vt[i].r32});
            expect_rsp(1, acc, vt[i].e32, {32'd0, vt[i].r32});
            expect_rsp(2, acc, vt[i].e64, vt[i].r64);
            check($sformatf("extra_rsp_v%0d", i), 64'(qa.size() + qb.size() + qc.size()), 64'd0);
        end

        // Back-to-back stores then loads, one request per cycle.
        seq_exp[0] = 32'h0; seq_exp[1] = 32'h0; seq_exp[2] = 32'h0;
        seq_exp[3] = 32'h11111111; seq_exp[4] = 32'h22222222; seq_exp[5] = 32'h33333333;
        issue(1'b1, 3'b010, 9'h000, 64'h11111111, accs[0]);
        issue(1'b1, 3'b010, 9'h004, 64'h22222222, accs[1]);
        issue(1'b1, 3'b010, 9'h008, 64'h33333333, accs[2]);
        issue(1'b0, 3'b010, 9'h000, 64'h0, accs[3]);
        issue(1'b0, 3'b010, 9'h004, 64'h0, accs[4]);
        issue(1'b0, 3'b010, 9'h008, 64'h0, accs[5]);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            expect_rsp(0, accs[i], 1'b0, {32'd0, seq_exp[i]});
            expect_rsp(1, accs[i], 1'b0, {32'd0, seq_exp[i]});
            expect_rsp(2, accs[i], 1'b0, {32'd0, seq_exp[i]});
        end

        // Reset with a load in flight, then again partway through the clear.
        issue(1'b0, 3'b010, 9'h008, 64'h0, acc);
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("inflight");
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_clear_busy", {61'd0, busy_a, busy_b, busy_c}, 64'h7);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midclear");
        clear_pass("reclear");
        check("no_rsp_across_reset", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

        issue(1'b0, 3'b010, 9'h008, 64'h0, acc);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        expect_rsp(0, acc, 1'b0, 64'h0);
        expect_rsp(1, acc, 1'b0, 64'h0);
        expect_rsp(2, acc, 1'b0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/datamemory_be.md
Name: datamemory_be

Overview:
Parametrised successor to the pipeline's data memory. Single-port, byte-addressed RAM with a valid/ready request interface and full RISC-V load/store width support: byte-enable stores and sign- or zero-extended loads. It adds misalignment and illegal-funct3 error reporting, a configurable pipelined read latency, and a post-reset hardware clear sequence. It sits in the MEM stage and is driven by the ALU address, rs2 data and instruction bits 14:12.

Parameters:
DM_ADDRESS, 9, byte-address width; memory size is 2^DM_ADDRESS bytes.
DATA_W, 32, word width; only 32 or 64 are legal; B = DATA_W/8 bytes per word.
RD_LAT, 1, request-to-response latency in cycles; legal range 1..4; fully pipelined.
CLEAR_ON_RESET, 1, when 1, zero every word after reset.

Ports:
clk  in  1  clock, all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
Funct3  in  3  instruction bits 14:12.
a  in  DM_ADDRESS  byte address.
wd  in  DATA_W  store data, right-aligned.
rsp_valid  out  1  response strobe.
rsp_err  out  1  qualifies rsp_valid: misaligned or illegal access.
rd  out  DATA_W  load data, extended per Funct3.
busy  out  1  high during the CLEAR state.

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - rsp_valid=0, rsp_err=0, rd=0.
  - The response pipeline is flushed.
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN.
  - Memory contents are not reset directly.
- State machine:
  - CLEAR: word counter runs 0..2^DM_ADDRESS/B-1 and writes 0 to one word per cycle. busy=1, req_ready=0. After the last word, next state is RUN.
  - RUN: req_ready=1, busy=0.
  - Reset asserted during CLEAR restarts the counter at 0.
- Accept: a request is accepted on an edge where req_valid && req_ready. One request per cycle; no back-pressure on responses.
- Word index = a[DM_ADDRESS-1:log2(B)]; byte offset = a[log2(B)-1:0].
- Legal Funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU only when DATA_W=64.
  - Stores: 000 SB, 001 SH, 010 SW; 011 SD only when DATA_W=64.
  - Any other code is illegal.
- Alignment: halfword needs a[0]=0, word needs a[1:0]=0, doubleword needs a[2:0]=0.
- Error access (misaligned or illegal): no memory write occurs; response has rsp_err=1 and rd=0.
- Store:
  - Byte enables are derived from size and offset.
  - wd lanes are replicated and shifted to the offset; only enabled bytes are written, on the accept edge.
  - The response returns with rd=0.
- Load:
  - Selected bytes are shifted down by the offset.
  - Signed codes sign-extend to DATA_W; unsigned codes and LW on DATA_W=32 are handled per the table.
- Response timing: rsp_valid pulses exactly RD_LAT cycles after the accept edge, in request order, for both loads and stores.
- Ordering: a load accepted on the edge after a store to the same bytes returns the new data (write occurs at the store's accept edge, the read samples after it).
- Simultaneous events: reset overrides all; no request is accepted in CLEAR.
- Address wrap is impossible since a spans exactly the array. rd holds its last value when rsp_valid=0.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, DATA_W=32, DM_ADDRESS=9 -> busy=1 and req_ready=0 for exactly 128 cycles; then RUN; LW a=0x1FC returns rd=0x00000000.
2. SW a=0x010 wd=0x8899AABB, then LB a=0x012 / LBU a=0x012 / LH a=0x012 / LHU a=0x012 -> rd=0xFFFFFF99 / 0x00000099 / 0xFFFF8899 / 0x00008899, each with rsp_valid at RD_LAT.
3. Byte enables: SW a=0x020 wd=0x11223344, SB a=0x021 wd=0x000000EE, SH a=0x022 wd=0x0000CAFE; LW a=0x020 -> rd=0xCAFEEE44.
4. SH a=0x031, then LW a=0x032 (misaligned) -> rsp_err=1, rd=0, memory word 0x030 unchanged; Funct3=111 load -> rsp_err=1.
5. RD_LAT=3, back-to-back loads of addresses 0x000, 0x004, 0x008 on consecutive cycles -> three consecutive rsp_valid pulses starting 3 cycles after the first accept, data in order.
6. Reset asserted at CLEAR cycle 50 and at a cycle where a response is in flight -> counter restarts (128 more cycles), no rsp_valid emitted; DATA_W=64 build: SD then LWU a=0x004 of 0xDEADBEEF_01234567 -> rd=0x00000000DEADBEEF.
